mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single main-memory port between the I-cache and D-cache refill/write-back requests. It sits between the two cache controllers and the memory model, below the IF and MEM stages. It serialises line transactions, routes the memory response back to the requester that owns the transaction, and counts grants and conflicts for performance reporting. The caches see it as a memory: hold `valid` until `ready`.

## Interface
Parameters:
- `LINE_W`, default 128: cache line width in bits. Equals the width of `cache_data_type`.
- `ADDR_W`, default 32: byte address width.

Ports:
- `clk_i`  in  1: clock. Single clock domain.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `icache_req_i`  in  `mem_req_type`: I-cache request {addr, data, rw, valid}.
- `icache_data_o`  out  `mem_data_type`: I-cache response {data, ready}.
- `dcache_req_i`  in  `mem_req_type`: D-cache request.
- `dcache_data_o`  out  `mem_data_type`: D-cache response.
- `mem_req_o`  out  `mem_req_type`: request to main memory (registered).
- `mem_data_i`  in  `mem_data_type`: main-memory response.
- `busy_o`  out  1: high when the FSM is not in IDLE.
- `no_igrant_o`  out  32: I-cache grants since reset.
- `no_dgrant_o`  out  32: D-cache grants since reset.
- `no_conflict_o`  out  32: cycles in which both requests were valid while the FSM was in IDLE.

## Operation
- **FSM states:** IDLE, BUSY_I, BUSY_D, DONE.
- **IDLE:** sample both `valid`s.
  - Only one valid: grant that side.
  - Both valid: grant the side selected by `prio_d`.
    - `prio_d=1` grants D.
    - `prio_d=0` grants I.
  - On any grant:
    - latch the winner's addr, data and rw into `req_q`;
    - set `mem_req_o.valid`;
    - go to BUSY_I or BUSY_D;
    - set `prio_d` to point at the loser (grant I sets `prio_d=1`; grant D sets `prio_d=0`).
- **BUSY_x:** hold `mem_req_o` stable and ignore new requests.
  - On `mem_data_i.ready=1`, combinationally drive the granted response:
    - `.data=mem_data_i.data`;
    - `.ready=1`.
  - In the same cycle, clear `mem_req_o.valid` at the next edge and go to DONE.
- **DONE:** one turnaround cycle, so the requester can drop its stale `valid`. Go to IDLE unconditionally.
- **Non-granted response port:** `data=0`, `ready=0` at all times. `ready` is never high on both ports.
- **rw and data:** `rw` and write data are forwarded unchanged. A D-cache write-back (`rw=1`) completes on `ready` exactly like a read.
- **Counters:** wrap modulo 2^32.
  - `no_igrant_o` and `no_dgrant_o` increment on the grant edge.
  - `no_conflict_o` increments in IDLE when both valids are high.
- **`mem_data_i.ready` outside BUSY:** ignored.

## Timing
- **Reset values:**
  - state = IDLE;
  - `mem_req_o` = all zero;
  - `prio_d` = 1;
  - all counters = 0;
  - both response ports = 0;
  - `busy_o` = 0.
- **Grant latency:** request valid in IDLE at cycle t gives `mem_req_o.valid=1` from cycle t+1.
- **Response latency:** `mem_data_i.ready` at cycle n gives requester `ready=1` at cycle n. It is zero-latency pass-through, one cycle wide.
- **Turnaround:** cycle n+1 is DONE and cycle n+2 is IDLE. The earliest next grant is visible at n+3.
- **Minimum transaction:** with memory `ready` at t+1, a full transaction is 3 cycles.
- **Simultaneous events:**
  - A new request on the other port during BUSY waits; no starvation, because `prio_d` alternates.
  - Both valid after reset: D is granted first.
- **Requester dropping `valid` during BUSY:** the transaction still completes and `ready` is still pulsed.
- **Reset mid-transaction:** immediate return to reset values. The outstanding memory access is abandoned and memory must tolerate `valid` dropping.

## Structure
- `mem_req_type`, `mem_data_type`, `cache_data_type` and the `LINE_W` constant come from `cache_def`.
- Add `arb_state_type` (the enum) to `cache_def`.
- No sub-module is needed. The three counters may use one shared `perf_counter` instance each, if one already exists in `cache_def` users.

## Test plan
- **Single I request:** I addr=0x0000_0040, rw=0; memory ready 2 cycles after valid with data=0x…DEAD.
  - `icache_data_o.ready` is pulsed once with that data.
  - `no_igrant_o=1`.
  - `dcache_data_o` stays 0.
- **Conflict:** both valid at the same cycle after reset.
  - D is granted first (`mem_req_o.addr`=D addr); I follows, with its grant visible 3 cycles after D's `ready`.
  - `no_conflict_o=1` (I is still waiting in IDLE after D completes, so expect `no_conflict_o=1` only if D has dropped `valid`).
- **Fairness:** both requesters assert back-to-back for 8 transactions. Grants alternate D,I,D,I…, and `no_dgrant_o=no_igrant_o=4`.
- **D write-back:** D request with rw=1, data=0x1111…, addr=0x100. `mem_req_o` carries identical fields and is stable until `ready`. `dcache_data_o.ready` is pulsed once.
- **Reset mid-BUSY:** `rst_ni` low in BUSY_I.
  - `mem_req_o.valid` drops asynchronously and all counters read 0.
  - After release, a fresh D request is granted normally.
- **Spurious ready:** `mem_data_i.ready=1` while IDLE. No response `ready` on either port and no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache/memory arbiter: bus structs, FSM state, line sizes.
`timescale 1ns/1ps
package mem_arbiter_pkg;

    localparam int CD_LINE_W = 128;
    localparam int CD_ADDR_W = 32;
    localparam int CD_CNT_W  = 32;

    typedef logic [CD_LINE_W-1:0] cache_data_type;

    // Request towards a memory: address, write data, direction, qualifier.
    typedef struct packed {
        logic [CD_ADDR_W-1:0] addr;
        cache_data_type       data;
        logic                 rw;
        logic                 valid;
    } mem_req_type;

    // Response from a memory: read data plus one-cycle completion strobe.
    typedef struct packed {
        cache_data_type data;
        logic           ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_type;

    // Free-running wrap-around increment used by the performance counters.
    function automatic logic [CD_CNT_W-1:0] cnt_inc(input logic [CD_CNT_W-1:0] v,
                                                    input logic              en);
        return v + {{(CD_CNT_W-1){1'b0}}, en};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's cache-side and memory-side buses.
// master: the caches and the memory model; slave: the arbiter.
`timescale 1ns/1ps
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    mem_req_type  icache_req;
    mem_data_type icache_data;
    mem_req_type  dcache_req;
    mem_data_type dcache_data;
    mem_req_type  mem_req;
    mem_data_type mem_data;

    modport master (
        output icache_req, dcache_req, mem_data,
        input  icache_data, dcache_data, mem_req
    );

    modport slave (
        input  icache_req, dcache_req, mem_data,
        output icache_data, dcache_data, mem_req
    );

endinterface

// File: rtl/mem_arbiter_perf.sv
// Bank of wrap-around 32-bit event counters, one per strobe bit.
`timescale 1ns/1ps
module mem_arbiter_perf
    import mem_arbiter_pkg::*;
#(
    parameter int N_CNT = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [N_CNT-1:0]                  i_inc,
    output logic [N_CNT-1:0][CD_CNT_W-1:0]    o_cnt
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
            logic [CD_CNT_W-1:0] r_cnt;

            // Count one event per cycle the strobe is high; cleared by reset.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= cnt_inc(r_cnt, i_inc[gi]);
                end
            end

            assign o_cnt[gi] = r_cnt;
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache. One line
// transaction at a time; alternating priority on conflicts; the memory
// ready/data is routed straight back to the owner of the transaction.
`timescale 1ns/1ps
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_W = CD_LINE_W,
    parameter int ADDR_W = CD_ADDR_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  mem_req_type   icache_req_i,
    output mem_data_type  icache_data_o,
    input  mem_req_type   dcache_req_i,
    output mem_data_type  dcache_data_o,
    output mem_req_type   mem_req_o,
    input  mem_data_type  mem_data_i,
    output logic          busy_o,
    output logic [31:0]   no_igrant_o,
    output logic [31:0]   no_dgrant_o,
    output logic [31:0]   no_conflict_o
);

    arb_state_type       r_state;
    logic                r_prio_d;
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_data;
    logic                r_rw;
    logic                r_valid;

    logic                w_idle;
    logic                w_both;
    logic                w_grant_d;
    logic                w_grant_i;
    logic                w_resp_i;
    logic                w_resp_d;
    logic [2:0]          w_inc;
    logic [2:0][31:0]    w_cnt;

    // Arbitration only takes effect in IDLE; D wins when it is alone or holds priority.
    assign w_idle    = (r_state == IDLE);
    assign w_both    = icache_req_i.valid & dcache_req_i.valid;
    assign w_grant_d = w_idle & dcache_req_i.valid & (~icache_req_i.valid | r_prio_d);
    assign w_grant_i = w_idle & icache_req_i.valid & ~w_grant_d;

    // Memory completion is only meaningful while a transaction is outstanding.
    assign w_resp_i  = (r_state == BUSY_I) & mem_data_i.ready;
    assign w_resp_d  = (r_state == BUSY_D) & mem_data_i.ready;

    // Transaction FSM: grant, wait for memory, one turnaround cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_prio_d <= 1'b1;
            r_addr   <= '0;
            r_data   <= '0;
            r_rw     <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_addr   <= dcache_req_i.addr;
                        r_data   <= dcache_req_i.data;
                        r_rw     <= dcache_req_i.rw;
                        r_valid  <= 1'b1;
                        r_prio_d <= 1'b0;
                        r_state  <= BUSY_D;
                    end else if (w_grant_i) begin
                        r_addr   <= icache_req_i.addr;
                        r_data   <= icache_req_i.data;
                        r_rw     <= icache_req_i.rw;
                        r_valid  <= 1'b1;
                        r_prio_d <= 1'b1;
                        r_state  <= BUSY_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_data_i.ready) begin
                        r_valid <= 1'b0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_o = {r_addr, r_data, r_rw, r_valid};
    assign busy_o    = ~w_idle;

    // Zero-latency response routing; the non-owning port stays all zero.
    always_comb begin
        icache_data_o = '0;
        dcache_data_o = '0;
        if (w_resp_i) begin
            icache_data_o.data  = mem_data_i.data;
            icache_data_o.ready = 1'b1;
        end
        if (w_resp_d) begin
            dcache_data_o.data  = mem_data_i.data;
            dcache_data_o.ready = 1'b1;
        end
    end

    assign w_inc = {w_idle & w_both, w_grant_d, w_grant_i};

    mem_arbiter_perf #(
        .N_CNT (3)
    ) u_perf (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_inc  (w_inc),
        .o_cnt  (w_cnt)
    );

    assign no_igrant_o   = w_cnt[0];
    assign no_dgrant_o   = w_cnt[1];
    assign no_conflict_o = w_cnt[2];

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: transaction-level arbitration model,
// requester and memory agents driven per cycle, directed scenarios on top.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [31:0] igr, dgr, conf;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.LINE_W(CD_LINE_W), .ADDR_W(CD_ADDR_W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .icache_req_i  (bus.icache_req),
        .icache_data_o (bus.icache_data),
        .dcache_req_i  (bus.dcache_req),
        .dcache_data_o (bus.dcache_data),
        .mem_req_o     (bus.mem_req),
        .mem_data_i    (bus.mem_data),
        .busy_o        (busy),
        .no_igrant_o   (igr),
        .no_dgrant_o   (dgr),
        .no_conflict_o (conf)
    );

    int nchk = 0;
    int nerr = 0;

    // requester agents, index 0 = I-cache, 1 = D-cache
    logic         out_pend [2];
    logic         vdrop    [2];
    logic [31:0]  q_addr   [2];
    logic [127:0] q_data   [2];
    logic         q_rw     [2];
    int           quota    [2];
    int           iss      [2];
    int           obs_cnt  [2];
    logic [127:0] obs_data [2];
    int           dlog[$];

    // transaction-level arbiter model
    int           cyc;
    int           m_owner;
    int           m_g, m_rc, m_free, m_last_r;
    bit           m_prio_d;
    int           m_gr [2];
    int           m_conf;
    logic [127:0] mem_dat;

    // stimulus knobs
    bit           rnd_mode;
    int           spur_pct, drop_pct, fixed_lat;
    bit           use_fixed;
    logic [127:0] fixed_data;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic init_model();
        for (int s = 0; s < 2; s++) begin
            out_pend[s] = 0; vdrop[s] = 0; q_addr[s] = 0; q_data[s] = 0; q_rw[s] = 0;
            quota[s] = 0; iss[s] = 0; obs_cnt[s] = 0; obs_data[s] = 0; m_gr[s] = 0;
        end
        dlog.delete();
        cyc = 0; m_owner = -1; m_g = -10; m_rc = -10; m_free = 0; m_last_r = -10;
        m_prio_d = 1; m_conf = 0;
        rnd_mode = 0; spur_pct = 0; drop_pct = 0; fixed_lat = -1; use_fixed = 0; fixed_data = 0;
    endtask

    task automatic new_req(input int s, input logic [31:0] a, input logic [127:0] d, input logic rw);
        out_pend[s] = 1; vdrop[s] = 0;
        q_addr[s] = a; q_data[s] = d; q_rw[s] = rw;
        iss[s]++;
    endtask

    task automatic new_rnd_req(input int s);
        new_req(s, {$urandom_range(0, 32'h0FFF_FFFF), 4'h0}, rnd128(),
                (s == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        bus.icache_req = '0;
        bus.dcache_req = '0;
        bus.mem_data   = '0;
        init_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // One clock cycle: drive agents after the edge, check on the falling edge.
    task automatic tick();
        logic         vi, vd, real_rdy, both;
        int           gs, lat;
        mem_data_type exp_p [2];
        mem_req_type  exp_req;
        logic         exp_valid, exp_busy;

        @(posedge clk); #1;
        cyc++;
        vi = out_pend[0] && !vdrop[0];
        vd = out_pend[1] && !vdrop[1];
        gs = -1; both = 0; real_rdy = 0;
        if (m_owner < 0 && cyc >= m_free && (vi || vd)) begin
            both = vi && vd;
            gs = both ? (m_prio_d ? 1 : 0) : (vd ? 1 : 0);
            m_owner = gs; m_g = cyc; m_prio_d = (gs == 0);
            lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            m_rc = cyc + 2 + lat;
        end
        bus.icache_req = {q_addr[0], q_data[0], q_rw[0], vi};
        bus.dcache_req = {q_addr[1], q_data[1], q_rw[1], vd};
        if (m_owner >= 0 && cyc == m_rc) begin
            real_rdy = 1;
            mem_dat  = use_fixed ? fixed_data : rnd128();
            bus.mem_data = {mem_dat, 1'b1};
        end else if ((m_owner < 0 || cyc == m_g) && int'($urandom_range(0, 99)) < spur_pct) begin
            bus.mem_data = {rnd128(), 1'b1};
        end else begin
            bus.mem_data = {rnd128(), 1'b0};
        end

        @(negedge clk);
        for (int s = 0; s < 2; s++)
            exp_p[s] = (real_rdy && m_owner == s) ? {mem_dat, 1'b1} : '0;
        nchk++;
        if (bus.icache_data !== exp_p[0]) begin
            nerr++; $display("FAIL icache_resp cyc=%0d got=%h exp=%h", cyc, bus.icache_data, exp_p[0]);
        end
        nchk++;
        if (bus.dcache_data !== exp_p[1]) begin
            nerr++; $display("FAIL dcache_resp cyc=%0d got=%h exp=%h", cyc, bus.dcache_data, exp_p[1]);
        end
        exp_valid = (m_owner >= 0) && (cyc > m_g);
        exp_busy  = exp_valid || (cyc == m_last_r + 1);
        nchk++;
        if (bus.mem_req.valid !== exp_valid) begin
            nerr++; $display("FAIL mem_valid cyc=%0d got=%b exp=%b", cyc, bus.mem_req.valid, exp_valid);
        end
        if (exp_valid) begin
            exp_req = {q_addr[m_owner], q_data[m_owner], q_rw[m_owner], 1'b1};
            nchk++;
            if (bus.mem_req !== exp_req) begin
                nerr++; $display("FAIL mem_req cyc=%0d got=%h exp=%h", cyc, bus.mem_req, exp_req);
            end
        end
        nchk++;
        if (busy !== exp_busy) begin
            nerr++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
        end
        nchk++;
        if (igr !== 32'(m_gr[0]) || dgr !== 32'(m_gr[1]) || conf !== 32'(m_conf)) begin
            nerr++; $display("FAIL counters cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                             cyc, igr, dgr, conf, m_gr[0], m_gr[1], m_conf);
        end

        // DUT-observed completions
        if (bus.icache_data.ready) begin obs_cnt[0]++; obs_data[0] = bus.icache_data.data; dlog.push_back(0); end
        if (bus.dcache_data.ready) begin obs_cnt[1]++; obs_data[1] = bus.dcache_data.data; dlog.push_back(1); end

        // model bookkeeping for the next cycle
        if (gs >= 0) m_gr[gs]++;
        if (both) m_conf++;
        if (real_rdy) begin
            int s;
            s = m_owner;
            out_pend[s] = 0; vdrop[s] = 0;
            m_last_r = cyc; m_free = cyc + 2; m_owner = -1;
            if (quota[s] > 0) begin quota[s]--; new_rnd_req(s); end
        end else if (m_owner >= 0 && !vdrop[m_owner] && int'($urandom_range(0, 99)) < drop_pct) begin
            vdrop[m_owner] = 1;
        end
        if (rnd_mode)
            for (int s = 0; s < 2; s++)
                if (!out_pend[s] && $urandom_range(0, 99) < 30) new_rnd_req(s);
    endtask

    task automatic test_reset();
        rst_n = 0;
        #3;
        nchk++;
        if (bus.mem_req !== '0 || busy !== 1'b0) begin
            nerr++; $display("FAIL reset_hold req=%h busy=%b exp=0/0", bus.mem_req, busy);
        end
        do_reset();
        nchk++;
        if (bus.mem_req !== '0 || busy !== 1'b0 || bus.icache_data !== '0 || bus.dcache_data !== '0) begin
            nerr++; $display("FAIL reset_outputs req=%h busy=%b i=%h d=%h exp=0",
                             bus.mem_req, busy, bus.icache_data, bus.dcache_data);
        end
        nchk++;
        if (igr !== 0 || dgr !== 0 || conf !== 0) begin
            nerr++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", igr, dgr, conf);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_i();
        logic [127:0] dead;
        do_reset();
        dead = 128'h0123_4567_89AB_CDEF_0011_2233_4455_DEAD;
        fixed_lat = 1; use_fixed = 1; fixed_data = dead;
        new_req(0, 32'h0000_0040, rnd128(), 1'b0);
        for (int k = 0; k < 50 && obs_cnt[0] == 0; k++) tick();
        repeat (4) tick();
        nchk++;
        if (obs_cnt[0] !== 1 || obs_data[0] !== dead) begin
            nerr++; $display("FAIL single_i_resp cnt=%0d data=%h exp=1/%h", obs_cnt[0], obs_data[0], dead);
        end
        nchk++;
        if (igr !== 1 || obs_cnt[1] !== 0) begin
            nerr++; $display("FAIL single_i_grants igr=%0d dresp=%0d exp=1/0", igr, obs_cnt[1]);
        end
        $display("test_single_i done igr=%0d", igr);
    endtask

    task automatic test_conflict();
        do_reset();
        new_req(0, 32'h0000_1000, rnd128(), 1'b0);
        new_req(1, 32'h0000_2000, rnd128(), 1'b0);
        for (int k = 0; k < 80 && obs_cnt[0] + obs_cnt[1] < 2; k++) tick();
        repeat (3) tick();
        nchk++;
        if (dlog.size() != 2 || dlog[0] != 1 || dlog[1] != 0) begin
            nerr++; $display("FAIL conflict_order got=%p exp='{1,0}", dlog);
        end
        nchk++;
        if (conf !== 1) begin
            nerr++; $display("FAIL conflict_count got=%0d exp=1", conf);
        end
        $display("test_conflict done conf=%0d", conf);
    endtask

    task automatic test_fairness();
        int exp_side;
        do_reset();
        quota[0] = 3; quota[1] = 3;
        new_rnd_req(0);
        new_rnd_req(1);
        for (int k = 0; k < 300 && dlog.size() < 8; k++) tick();
        repeat (3) tick();
        nchk++;
        if (dlog.size() != 8) begin
            nerr++; $display("FAIL fair_count got=%0d exp=8", dlog.size());
        end
        for (int i = 0; i < dlog.size() && i < 8; i++) begin
            exp_side = (i % 2 == 0) ? 1 : 0;
            nchk++;
            if (dlog[i] != exp_side) begin
                nerr++; $display("FAIL fair_order idx=%0d got=%0d exp=%0d", i, dlog[i], exp_side);
            end
        end
        nchk++;
        if (igr !== 4 || dgr !== 4) begin
            nerr++; $display("FAIL fair_grants igr=%0d dgr=%0d exp=4/4", igr, dgr);
        end
        $display("test_fairness done igr=%0d dgr=%0d", igr, dgr);
    endtask

    task automatic test_writeback();
        do_reset();
        fixed_lat = 3;
        new_req(1, 32'h0000_0100, {8{16'h1111}}, 1'b1);
        for (int k = 0; k < 50 && obs_cnt[1] == 0; k++) tick();
        repeat (4) tick();
        nchk++;
        if (obs_cnt[1] !== 1 || obs_cnt[0] !== 0 || dgr !== 1) begin
            nerr++; $display("FAIL writeback dresp=%0d iresp=%0d dgr=%0d exp=1/0/1", obs_cnt[1], obs_cnt[0], dgr);
        end
        $display("test_writeback done dgr=%0d", dgr);
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        fixed_lat = 3;
        new_rnd_req(0);
        for (int k = 0; k < 20 && !(m_owner == 0 && cyc > m_g + 1); k++) tick();
        nchk++;
        if (!(busy === 1'b1 && bus.mem_req.valid === 1'b1)) begin
            nerr++; $display("FAIL midrst_setup busy=%b valid=%b exp=1/1", busy, bus.mem_req.valid);
        end
        #2 rst_n = 0;
        #1;
        nchk++;
        if (bus.mem_req.valid !== 1'b0 || busy !== 1'b0 || igr !== 0 || dgr !== 0 || conf !== 0) begin
            nerr++; $display("FAIL midrst_async valid=%b busy=%b cnt=%0d/%0d/%0d exp=0",
                             bus.mem_req.valid, busy, igr, dgr, conf);
        end
        do_reset();
        new_rnd_req(1);
        for (int k = 0; k < 50 && obs_cnt[1] == 0; k++) tick();
        repeat (3) tick();
        nchk++;
        if (obs_cnt[1] !== 1 || dgr !== 1 || igr !== 0) begin
            nerr++; $display("FAIL midrst_after dresp=%0d dgr=%0d igr=%0d exp=1/1/0", obs_cnt[1], dgr, igr);
        end
        $display("test_reset_mid_busy done");
    endtask

    task automatic test_spurious();
        do_reset();
        spur_pct = 100;
        repeat (4) tick();
        nchk++;
        if (busy !== 1'b0 || obs_cnt[0] + obs_cnt[1] != 0 || igr !== 0 || dgr !== 0) begin
            nerr++; $display("FAIL spurious busy=%b resp=%0d grants=%0d/%0d exp=0", busy,
                             obs_cnt[0] + obs_cnt[1], igr, dgr);
        end
        spur_pct = 0;
        new_rnd_req(0);
        for (int k = 0; k < 50 && obs_cnt[0] == 0; k++) tick();
        nchk++;
        if (obs_cnt[0] !== 1) begin
            nerr++; $display("FAIL spurious_after iresp=%0d exp=1", obs_cnt[0]);
        end
        $display("test_spurious done");
    endtask

    task automatic test_random();
        do_reset();
        rnd_mode = 1; spur_pct = 20; drop_pct = 20;
        repeat (600) tick();
        rnd_mode = 0;
        for (int k = 0; k < 100 && (out_pend[0] || out_pend[1]); k++) tick();
        repeat (3) tick();
        nchk++;
        if (obs_cnt[0] != iss[0] || obs_cnt[1] != iss[1]) begin
            nerr++; $display("FAIL random_complete resp=%0d/%0d issued=%0d/%0d",
                             obs_cnt[0], obs_cnt[1], iss[0], iss[1]);
        end
        nchk++;
        if (igr !== 32'(iss[0]) || dgr !== 32'(iss[1])) begin
            nerr++; $display("FAIL random_grants got=%0d/%0d exp=%0d/%0d", igr, dgr, iss[0], iss[1]);
        end
        $display("test_random done txns=%0d/%0d conf=%0d", iss[0], iss[1], conf);
    endtask

    initial begin
        init_model();
        bus.icache_req = '0;
        bus.dcache_req = '0;
        bus.mem_data   = '0;
        test_reset();
        test_single_i();
        test_conflict();
        test_fairness();
        test_writeback();
        test_reset_mid_busy();
        test_spurious();
        test_random();
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
